dcnn_s0_stream: RTL and testbench

- Stage-0 image streamer: fetches an m_size x m_size image from the on-chip image buffer and transmits it, row-major, as paired pixels on the two-lane image stream consumed by stage s1.
- Lane 0 carries even column indices; lane 1 carries odd column indices.
- Handles read latency and downstream backpressure with a 2-entry skid FIFO, and signals completion to the layer controller.

---
 rtl/dcnn_s0_stream.sv | 161 ++++++++++++++++
 tb/tb_dcnn_s0_stream.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dcnn_s0_stream.sv
// Stage-0 image streamer: reads an m_size x m_size image two pixels at a time
// and presents it row-major on a two-lane stream, buffered by a 2-entry skid FIFO.
module dcnn_s0_stream #(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int M_BITS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [M_BITS-1:0] m_size,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_rd_addr [0:1],
  input  logic [DW-1:0]     mem_rd_data [0:1],
  output logic [DW-1:0]     image_stream_out [0:1],
  output logic [1:0]        image_stream_out_valid,
  input  logic              image_stream_out_rdy [0:1]
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  state_t state_reg, state_next;

  logic [AW-1:0]     base_reg;
  logic [AW-1:0]     row_base_reg;
  logic [M_BITS-1:0] m_reg;
  logic [M_BITS-1:0] row_reg;
  logic [M_BITS:0]   col_reg;
  logic              inflight_reg;
  logic              mask_pend_reg;
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        occ_reg;

  logic [DW-1:0]     fifo_pix0 [0:1];
  logic [DW-1:0]     fifo_pix1 [0:1];
  logic              fifo_mask [0:1];

  logic [M_BITS:0]   col_plus2;
  logic              row_wrap;
  logic              last_pair;
  logic              mask_req;
  logic              accept;
  logic              fifo_wr;
  logic              fifo_pop;
  logic              head_mask;
  logic              head_any;
  logic [DW-1:0]     head_pix0;
  logic [DW-1:0]     head_pix1;
  logic [2:0]        remaining;
  logic [AW-1:0]     addr0;

  always_comb begin
    col_plus2 = col_reg + (M_BITS+1)'(2);
    row_wrap  = col_plus2 >= {1'b0, m_reg};
    last_pair = row_wrap && (row_reg == m_reg - 1'b1);
    mask_req  = (col_reg + (M_BITS+1)'(1)) != {1'b0, m_reg};
    mem_rd_en = (state_reg == FETCH) &&
                (({1'b0, occ_reg} + {2'b00, inflight_reg}) < 3'd2);
    addr0     = base_reg + row_base_reg + AW'(col_reg);
    mem_rd_addr[0] = mem_rd_en ? addr0 : '0;
    mem_rd_addr[1] = mem_rd_en ? addr0 + 1'b1 : '0;
  end

  // An empty FIFO is bypassed by the returning read so the first beat lands one cycle after the read.
  always_comb begin
    head_any  = 1'b0;
    head_mask = 1'b0;
    head_pix0 = '0;
    head_pix1 = '0;
    if (occ_reg != 2'd0) begin
      head_any  = 1'b1;
      head_mask = fifo_mask[rd_ptr_reg];
      head_pix0 = fifo_pix0[rd_ptr_reg];
      head_pix1 = fifo_pix1[rd_ptr_reg];
    end else if (inflight_reg) begin
      head_any  = 1'b1;
      head_mask = mask_pend_reg;
      head_pix0 = mem_rd_data[0];
      head_pix1 = mem_rd_data[1];
    end
    image_stream_out_valid = head_any ? {head_mask, 1'b1} : 2'b00;
    image_stream_out[0]    = head_any ? head_pix0 : '0;
    image_stream_out[1]    = (head_any && head_mask) ? head_pix1 : '0;
    accept    = head_any && image_stream_out_rdy[0] && image_stream_out_rdy[1];
    fifo_wr   = inflight_reg && !((occ_reg == 2'd0) && accept);
    fifo_pop  = accept && (occ_reg != 2'd0);
    remaining = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, accept};
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != IDLE);
    done       = (state_reg == FIN);
    case (state_reg)
      IDLE:    if (start) state_next = (m_size == '0) ? FIN : FETCH;
      FETCH:   if (mem_rd_en && last_pair) state_next = DRAIN;
      DRAIN:   if (remaining == 3'd0) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      m_reg         <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      row_base_reg  <= '0;
      inflight_reg  <= 1'b0;
      mask_pend_reg <= 1'b0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      occ_reg       <= 2'd0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= mem_rd_en;
      if (mem_rd_en) mask_pend_reg <= mask_req;
      if (state_reg == IDLE && start) begin
        base_reg     <= base_addr;
        m_reg        <= m_size;
        row_reg      <= '0;
        col_reg      <= '0;
        row_base_reg <= '0;
      end else if (mem_rd_en) begin
        if (row_wrap) begin
          col_reg      <= '0;
          row_reg      <= row_reg + 1'b1;
          row_base_reg <= row_base_reg + AW'(m_reg);
        end else begin
          col_reg <= col_plus2;
        end
      end
      if (fifo_wr)  wr_ptr_reg <= ~wr_ptr_reg;
      if (fifo_pop) rd_ptr_reg <= ~rd_ptr_reg;
      occ_reg <= occ_reg + {1'b0, fifo_wr} - {1'b0, fifo_pop};
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk) begin
        if (rst) begin
          fifo_pix0[gi] <= '0;
          fifo_pix1[gi] <= '0;
          fifo_mask[gi] <= 1'b0;
        end else if (fifo_wr && (wr_ptr_reg == gi[0])) begin
          fifo_pix0[gi] <= mem_rd_data[0];
          fifo_pix1[gi] <= mem_rd_data[1];
          fifo_mask[gi] <= mask_pend_reg;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_dcnn_s0_stream.sv
// Directed bench for dcnn_s0_stream: memory word = address, beats captured
// by a monitor and compared against hand-derived row-major pixel pairs.
module tb_dcnn_s0_stream;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [MB-1:0] m_size;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr [0:1];
  logic [DW-1:0] mem_rd_data [0:1];
  logic [DW-1:0] image_stream_out [0:1];
  logic [1:0]    image_stream_out_valid;
  logic          image_stream_out_rdy [0:1];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  dcnn_s0_stream #(.DW(DW), .AW(AW), .M_BITS(MB)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .m_size(m_size),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .image_stream_out(image_stream_out),
    .image_stream_out_valid(image_stream_out_valid),
    .image_stream_out_rdy(image_stream_out_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data is only meaningful exactly one cycle after a read; otherwise a poison value.
  always @(posedge clk) begin
    mem_rd_data[0] <= mem_rd_en ? mem_rd_addr[0] : 32'hDEAD_BEEF;
    mem_rd_data[1] <= mem_rd_en ? mem_rd_addr[1] : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  logic [2*DW+1:0] beats [$];
  int              beat_cyc [$];
  int              reads = 0;
  int              dones = 0;
  int              busy_cycles = 0;
  int              last_done_cyc = 0;
  int              outstanding = 0;
  logic            stall_prev = 1'b0;
  logic [2*DW+1:0] prev_beat = '0;

  always @(negedge clk) begin
    logic            acc;
    logic [2*DW+1:0] cur;
    cur = {image_stream_out[0], image_stream_out[1], image_stream_out_valid};
    acc = (image_stream_out_valid != 2'b00) && image_stream_out_rdy[0] && image_stream_out_rdy[1];
    if (rst) begin
      outstanding = 0;
      stall_prev  = 1'b0;
    end else begin
      if (stall_prev) check("stable_under_stall", cur, prev_beat);
      if (mem_rd_en) begin
        check("read_window", 128'(outstanding < 2), 128'd1);
        reads++;
      end
      if (acc) begin
        beats.push_back(cur);
        beat_cyc.push_back(cyc);
      end
      if (busy) busy_cycles++;
      if (done) begin
        dones++;
        last_done_cyc = cyc;
      end
      outstanding = outstanding + (mem_rd_en ? 1 : 0) - (acc ? 1 : 0);
      stall_prev  = (image_stream_out_valid != 2'b00) && !acc;
      prev_beat   = cur;
    end
  end

  task automatic set_rdy(input int mode, input int i);
    logic r;
    r = 1'b1;
    if (mode == 1) r = ((i % 4) == 0) || ((i % 4) == 3);
    image_stream_out_rdy[0] = r;
    image_stream_out_rdy[1] = (mode == 1 && i == 8) ? 1'b0 : r;
  endtask

  // mode 0: rdy high, 1: rdy toggling 1,0,0,1 with one lane-1-only stall, 2: start re-pulsed mid-fetch
  task automatic run_image(input logic [AW-1:0] b, input int m, input int mode,
                           input int exp_done, input string tag);
    int nb, nr, nd, nbusy, s, i, pairs, exp_beats;
    logic [AW-1:0] rb;
    logic [2*DW+1:0] exp_beat;
    nb = beats.size();
    nr = reads;
    nd = dones;
    nbusy = busy_cycles;
    pairs = (m + 1) / 2;
    exp_beats = m * pairs;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    m_size = MB'(m);
    s = cyc;
    set_rdy(mode, 0);
    i = 0;
    while (dones == nd && i < 3000) begin
      @(posedge clk); #1;
      i++;
      start = (mode == 2 && i == 3);
      set_rdy(mode, i);
    end
    start = 1'b0;
    set_rdy(0, 0);
    check({tag, "_done_seen"}, 128'(dones - nd), 128'd1);
    check({tag, "_idle_after"}, {busy, done}, 2'b00);
    check({tag, "_beat_count"}, 128'(beats.size() - nb), 128'(exp_beats));
    check({tag, "_read_count"}, 128'(reads - nr), 128'(exp_beats));
    for (int k = 0; k < exp_beats && (nb + k) < beats.size(); k++) begin
      rb = b + AW'((k / pairs) * m + 2 * (k % pairs));
      if (2 * (k % pairs) + 1 < m) exp_beat = {rb, rb + 32'd1, 2'b11};
      else                         exp_beat = {rb, 32'd0, 2'b01};
      check($sformatf("%s_beat%0d", tag, k), beats[nb + k], exp_beat);
    end
    if (exp_done >= 0) begin
      check({tag, "_done_cycle"}, 128'(last_done_cyc - s), 128'(exp_done));
      check({tag, "_busy_cycles"}, 128'(busy_cycles - nbusy), 128'(exp_done));
      if (m > 0 && beats.size() > nb)
        check({tag, "_first_beat_cycle"}, 128'(beat_cyc[nb] - s), 128'd2);
    end
  endtask

  initial begin
    int nb, nd, i;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    m_size = '0;
    set_rdy(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, done, mem_rd_en, image_stream_out_valid}, 5'b0);
    check("reset_data", {image_stream_out[0], image_stream_out[1], mem_rd_addr[0], mem_rd_addr[1]}, 128'd0);
    rst = 1'b0;

    run_image(32'h100, 4, 0, 10, "m4");
    run_image(32'h0,   3, 0, 8,  "m3");
    run_image(32'h100, 4, 1, -1, "m4_bp");
    run_image(32'h40,  0, 0, 1,  "m0");
    run_image(32'h55,  1, 0, 3,  "m1");
    run_image(32'h100, 4, 2, 10, "m4_restart");

    nb = beats.size();
    nd = dones;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = 32'h200;
    m_size = 10'd4;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0;
    while ((beats.size() - nb) < 3 && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    check("rst_third_beat_seen", 128'(beats.size() - nb >= 3), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ctrl", {busy, done, mem_rd_en, image_stream_out_valid}, 5'b0);
    check("rst_mid_data", {image_stream_out[0], image_stream_out[1], mem_rd_addr[0], mem_rd_addr[1]}, 128'd0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("rst_no_done", 128'(dones - nd), 128'd0);
    check("rst_idle", {busy, mem_rd_en}, 2'b00);
    run_image(32'h300, 4, 0, 10, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
